single_port_ram: RTL and testbench

- Synchronous single-port RAM: 4096 words x 8 bits, one shared address bus for read and write.
- Write-enable selects between a write and a read on each rising clock edge.
- Used as a general-purpose on-chip scratch/data buffer, inferable as block RAM with a registered output.

---
 rtl/single_port_ram_pkg.sv | 18 +
 rtl/single_port_ram_if.sv | 37 +++
 rtl/single_port_ram.sv | 49 ++++
 tb/tb_single_port_ram.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/single_port_ram_pkg.sv
// Shared RAM geometry and word/address types for the scratch-buffer RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents:
//   RAM_ADDR_WIDTH - default address width (depth = 2**RAM_ADDR_WIDTH words)
//   RAM_DATA_WIDTH - default word width in bits
//   ram_addr_t     - address type at the default geometry
//   ram_word_t     - data word type at the default geometry
package ram_pkg;

    localparam int RAM_ADDR_WIDTH = 12;
    localparam int RAM_DATA_WIDTH = 8;

    typedef logic [RAM_ADDR_WIDTH-1:0] ram_addr_t;
    typedef logic [RAM_DATA_WIDTH-1:0] ram_word_t;

endpackage

// File: rtl/single_port_ram_if.sv
// Access bus for the single-port RAM: one shared address, one write enable.
// Latency: read data appears one clock after the address is sampled.
// Backpressure: none; every cycle carries exactly one access, always accepted.
//
// Signals:
//   addr     - word address, shared by reads and writes
//   data_in  - write data, only meaningful when wr_en=1
//   wr_en    - 1 = write cycle, 0 = read cycle
//   data_out - registered read data from the RAM
// Modports: master drives the access, slave is the RAM itself.
interface single_port_ram_if
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
);

    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output addr,
        output data_in,
        output wr_en,
        input  data_out
    );

    modport slave (
        input  addr,
        input  data_in,
        input  wr_en,
        output data_out
    );

endinterface

// File: rtl/single_port_ram.sv
// Synchronous single-port RAM (2**ADDR_WIDTH x DATA_WIDTH) with a registered read port.
// Latency: 1 cycle from the read edge to data_out; writes complete on their edge.
// Backpressure: none; one access per clock, always accepted.
//
// Ports:
//   clk - rising-edge clock for storage and output register
//   rst - asynchronous active-high reset; clears data_out only, never the array
//   bus - single_port_ram_if slave: addr, data_in, wr_en in; data_out out
module single_port_ram
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = RAM_DATA_WIDTH
)
(
    input  logic              clk,
    input  logic              rst,
    single_port_ram_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Plain array with one clocked write process and no reset so synthesis maps it
    // onto block RAM. Contents are undefined until written.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;

    // Write port. rst is sampled as a level here: the edge that coincides with a
    // held or just-releasing reset performs no write.
    always_ff @(posedge clk) begin
        if (!rst && bus.wr_en) begin
            mem[bus.addr] <= bus.data_in;
        end
    end

    // Output register. Only loads on read cycles, so it holds across writes
    // (no write-through). A read right after a write to the same address sees
    // the new word because the array was updated on the previous edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out_q <= '0;
        end else if (!bus.wr_en) begin
            data_out_q <= mem[bus.addr];
        end
    end

    assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_single_port_ram.sv
// Self-checking bench for single_port_ram: directed cases plus randomized traffic
// scored against an associative-array memory model.
// Stimulus pushes expected read data into a queue; a monitor pops it on every
// read edge and checks data_out at each falling edge.
module tb_single_port_ram
    import ram_pkg::*;
;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    single_port_ram_if bus ();

    single_port_ram dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        ram_word_t val;
        bit        chk;
        string     name;
    } exp_t;

    exp_t      exp_q [$];
    ram_word_t model [int];

    int checks = 0;
    int errors = 0;

    // Value data_out must currently show; unchecked after reads of unwritten words.
    ram_word_t cur_val  = '0;
    bit        cur_chk  = 1'b1;
    string     cur_name = "reset_value";

    // Monitor: each read edge outside reset consumes one expectation.
    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            cur_val  = '0;
            cur_chk  = 1'b1;
            cur_name = "reset_hold";
        end else if (bus.wr_en == 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_without_expect: read edge at %0t with empty queue (required a queued read)", $time);
                cur_chk = 1'b0;
            end else begin
                e        = exp_q.pop_front();
                cur_val  = e.val;
                cur_chk  = e.chk;
                cur_name = e.name;
            end
        end
    end

    always @(negedge clk) begin
        if (cur_chk) begin
            checks++;
            if (bus.data_out !== cur_val) begin
                errors++;
                $display("FAIL %s: data_out=%h required=%h at %0t", cur_name, bus.data_out, cur_val, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input ram_addr_t a, input ram_word_t d);
        bus.wr_en   = 1'b1;
        bus.addr    = a;
        bus.data_in = d;
        if (!rst) model[int'(a)] = d;
    endtask

    task automatic drive_read(input ram_addr_t a, input string nm);
        exp_t e;
        bus.wr_en   = 1'b0;
        bus.addr    = a;
        bus.data_in = 'z;
        e.chk  = model.exists(int'(a));
        e.val  = '0;
        if (e.chk) e.val = model[int'(a)];
        e.name = nm;
        if (!rst) exp_q.push_back(e);
    endtask

    ram_addr_t pool [16];

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;

        // Release reset away from the clock edge; next edge writes a scratch word.
        step();
        step();
        rst = 1'b0;
        drive_write(12'h300, 8'h9C);

        // Load AA into data_out, then reset mid-cycle.
        step(); drive_write(12'h100, 8'hAA);
        step(); drive_read(12'h100, "pre_reset_read");
        step(); drive_write(12'h301, 8'h12);
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.data_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: data_out=%h required=00 before any clock edge", bus.data_out);
        end
        // Writes during reset must not land in the array.
        drive_write(12'h100, 8'h11);
        step();
        step();
        rst = 1'b0;
        drive_write(12'h302, 8'h44);
        step(); drive_write(12'h303, 8'h45);
        step(); drive_read(12'h100, "reset_blocks_write");
        step(); drive_read(12'h300, "post_release_write");

        // Sequential writes then reads.
        step(); drive_write(12'd0, 8'h3F);
        step(); drive_write(12'd1, 8'hD4);
        step(); drive_write(12'd2, 8'hCD);
        step(); drive_read(12'd0, "seq_rd0");
        step(); drive_read(12'd1, "seq_rd1");
        step(); drive_read(12'd2, "seq_rd2");

        // Output holds through a write.
        step(); drive_read(12'd1, "hold_rd1");
        step(); drive_write(12'd5, 8'h55);
        step(); drive_read(12'd5, "hold_rd5");

        // Read immediately after write, same address.
        step(); drive_write(12'hFFF, 8'h77);
        step(); drive_read(12'hFFF, "raw_fff");

        // data_in floating during reads leaves memory alone.
        step(); drive_read(12'd0, "z_rd0_a");
        step(); drive_read(12'd1, "z_rd1");
        step(); drive_read(12'd0, "z_rd0_b");

        // Address extremes, no aliasing.
        step(); drive_write(12'h000, 8'h01);
        step(); drive_write(12'hFFF, 8'hFE);
        step(); drive_read(12'h000, "ext_rd000");
        step(); drive_read(12'hFFF, "ext_rdfff");

        // Randomized traffic over a pool that includes extremes and high-bit neighbours.
        pool[0] = 12'h000;
        pool[1] = 12'hFFF;
        pool[2] = 12'h800;
        pool[3] = 12'h7FF;
        for (int i = 4; i < 16; i++) pool[i] = ram_addr_t'($urandom_range(0, 4095));
        for (int i = 0; i < 400; i++) begin
            ram_addr_t a;
            a = pool[$urandom_range(0, 15)];
            step();
            if ($urandom_range(0, 1) == 1) drive_write(a, ram_word_t'($urandom_range(0, 255)));
            else                           drive_read(a, "rand_rd");
        end

        // Drain: a final write edge consumes nothing, then confirm the queue emptied.
        step(); drive_write(12'h000, 8'h00);
        step();
        step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d reads outstanding, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
